// File: rtl/elevator_pkg.sv
// elevator_pkg: shared floor widths, FSM state encoding and floor/bit helpers
//   FLOOR_W/NUM_FLOORS size the floor number and request mask.
//   floor_bit(f) maps floor f (1..7) onto its one-hot pending bit f-1.
package elevator_pkg;
  localparam int FLOOR_W = 3;
  localparam int NUM_FLOORS = 7;
  typedef logic [FLOOR_W-1:0] floor_t;
  typedef logic [NUM_FLOORS-1:0] fmask_t;
  typedef enum logic [1:0] {IDLE = 2'b00, SELECT = 2'b01, SERVE = 2'b10, DWELL = 2'b11} state_e;
  typedef struct packed {
    floor_t flr;
    logic   up;
  } sel_t;
  localparam floor_t GROUND = floor_t'(1);
  function automatic fmask_t floor_bit(input floor_t f);
    return fmask_t'(1) << (f - GROUND);
  endfunction
endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: synchroniser, debounce counter and rising-edge press pulse for one button
//   clk, rst_n : clock, async active-low reset
//   btn_i      : raw asynchronous button level
//   press_o    : one-cycle pulse when the debounced level rises
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_i,
  output logic press_o
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  logic [1:0] sync_q;
  logic lvl_q, lvl_prev_q;
  logic [CW-1:0] cnt_q;
  // counter only runs while the synchronised level disagrees with the accepted one
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      lvl_q <= 1'b0;
      lvl_prev_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      sync_q <= {sync_q[0], btn_i};
      lvl_prev_q <= lvl_q;
      if (sync_q[1] == lvl_q) cnt_q <= '0;
      else if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
        lvl_q <= sync_q[1];
        cnt_q <= '0;
      end else cnt_q <= cnt_q + 1'b1;
    end
  end
  assign press_o = lvl_q & ~lvl_prev_q;
endmodule

// File: rtl/call_scheduler.sv
// call_scheduler: debounced call latch and SCAN target selection for the elevator FSM
//   BTN[i]     : raw call for floor i+1        cur_floor : reported floor (0 read as 1)
//   target/go  : registered floor select / move enable
//   pending    : latched requests              door_open : high during dwell
//   dir_up     : scan direction (1 = up)
//   Optional: CALL_SCHED_CANCEL_EN makes a press on a pending floor cancel it.
module call_scheduler
  import elevator_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int DWELL_CYCLES = 200_000_000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_FLOORS-1:0] BTN,
  input  logic [FLOOR_W-1:0]    cur_floor,
  output logic [FLOOR_W-1:0]    target,
  output logic                  go,
  output logic [NUM_FLOORS-1:0] pending,
  output logic                  door_open,
  output logic                  dir_up
);
  localparam int DW_W = $clog2(DWELL_CYCLES + 1);
  state_e state_q, state_d;
  floor_t target_q, target_d, cf;
  fmask_t pending_q, pending_d, press, press_eff, cf_bit, clr;
  logic go_q, go_d, door_q, door_d, dir_up_q, dir_up_d;
  logic [DW_W-1:0] dwell_q, dwell_d;
  logic hit, arrive, restart, done, cancel;
  sel_t sel;
  for (genvar g = 0; g < NUM_FLOORS; g++) begin : g_btn
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clk(clk), .rst_n(rst_n), .btn_i(BTN[g]), .press_o(press[g])
    );
  end
  // keep direction while requests remain ahead, otherwise turn to the nearest below/above
  function automatic sel_t scan_sel(input fmask_t p, input floor_t f, input logic up);
    floor_t lo, hi;
    logic has_a, has_b;
    {lo, hi, has_a, has_b} = '0;
    for (int i = NUM_FLOORS - 1; i >= 0; i--)
      if (p[i] && i + 1 > int'(f)) begin
        has_a = 1'b1;
        lo = floor_t'(i + 1);
      end
    for (int i = 0; i < NUM_FLOORS; i++)
      if (p[i] && i + 1 < int'(f)) begin
        has_b = 1'b1;
        hi = floor_t'(i + 1);
      end
    return (up && has_a) ? sel_t'{flr: lo, up: 1'b1} :
           has_b ? sel_t'{flr: hi, up: 1'b0} : sel_t'{flr: lo, up: 1'b1};
  endfunction
  assign cf = (cur_floor == '0) ? GROUND : cur_floor;
  assign cf_bit = floor_bit(cf);
  assign sel = scan_sel(pending_q, cf, dir_up_q);
  assign hit = |(pending_q & cf_bit);
  assign arrive = cf == target_q;
  assign restart = |(press & cf_bit);
  assign done = dwell_q == DW_W'(DWELL_CYCLES - 1);
  // a call for the floor we are dwelling at just holds the door
  assign press_eff = (state_q == DWELL) ? press & ~cf_bit : press;
  assign clr = (state_q == SELECT || (state_q == SERVE && arrive)) ? cf_bit : '0;
`ifdef CALL_SCHED_CANCEL_EN
  assign pending_d = (pending_q ^ press_eff) & ~clr;
  assign cancel = |(press & pending_q & floor_bit(target_q));
`else
  assign pending_d = (pending_q | press_eff) & ~clr;
  assign cancel = 1'b0;
`endif
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else state_q <= state_d;
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:   state_d = (pending_q != '0) ? SELECT : IDLE;
      SELECT: state_d = hit ? DWELL : SERVE;
      SERVE:  state_d = arrive ? DWELL : cancel ? ((pending_d != '0) ? SELECT : IDLE) : SERVE;
      DWELL:  state_d = (done && !restart) ? ((pending_q != '0) ? SELECT : IDLE) : DWELL;
    endcase
  end
  always_comb begin
    target_d = (state_q == SELECT && !hit) ? sel.flr : target_q;
    dir_up_d = (state_q == SELECT && !hit) ? sel.up : dir_up_q;
    go_d = (state_q == SELECT) ? !hit : (state_q == SERVE) ? !(arrive || cancel) : 1'b0;
    door_d = state_d == DWELL;
    dwell_d = (state_q != DWELL || restart || done) ? '0 : dwell_q + 1'b1;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      target_q <= GROUND;
      go_q <= 1'b0;
      pending_q <= '0;
      door_q <= 1'b0;
      dir_up_q <= 1'b1;
      dwell_q <= '0;
    end else begin
      target_q <= target_d;
      go_q <= go_d;
      pending_q <= pending_d;
      door_q <= door_d;
      dir_up_q <= dir_up_d;
      dwell_q <= dwell_d;
    end
  end
  assign target = target_q;
  assign go = go_q;
  assign pending = pending_q;
  assign door_open = door_q;
  assign dir_up = dir_up_q;
endmodule

// File: tb/tb_call_scheduler.sv
// tb_call_scheduler: directed self-checking bench for call_scheduler (DEBOUNCE=4, DWELL=8)
module tb_call_scheduler;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [6:0] btn = '0;
  logic [2:0] cur_floor = 3'd1;
  logic [2:0] target;
  logic go, door_open, dir_up;
  logic [6:0] pending;
  int checks = 0;
  int fails = 0;
  always #5 clk = ~clk;
  call_scheduler #(.DEBOUNCE_CYCLES(4), .DWELL_CYCLES(8)) dut (
    .clk(clk), .rst_n(rst_n), .BTN(btn), .cur_floor(cur_floor),
    .target(target), .go(go), .pending(pending), .door_open(door_open), .dir_up(dir_up)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask
  // hold the buttons long enough for one press to latch (2 sync + 4 debounce + 1)
  task automatic press(input logic [6:0] m);
    btn = btn | m;
    step(7);
    btn = btn & ~m;
  endtask
  initial begin
    @(negedge clk);
    chk("rst_target", target, 3'd1);
    chk("rst_go", go, 1'b0);
    chk("rst_pending", pending, 7'b0);
    chk("rst_door", door_open, 1'b0);
    chk("rst_dir", dir_up, 1'b1);
    rst_n = 1'b1;
    // glitches of 3 cycles must be rejected
    repeat (2) begin
      btn[4] = 1'b1;
      step(3);
      btn[4] = 1'b0;
      step(3);
      chk("glitch_pending", pending, 7'b0);
    end
    btn[4] = 1'b1;
    step(6);
    chk("hold6_pending", pending, 7'b0);
    step(1);
    chk("hold7_pending", pending, 7'b0010000);
    btn[4] = 1'b0;
    step(1);
    chk("sel_go_low", go, 1'b0);
    step(1);
    chk("t1_target", target, 3'd5);
    chk("t1_go", go, 1'b1);
    chk("t1_dir", dir_up, 1'b1);
    cur_floor = 3'd5;
    step(1);
    chk("t1_arr_go", go, 1'b0);
    chk("t1_arr_door", door_open, 1'b1);
    chk("t1_arr_pending", pending, 7'b0);
    step(7);
    chk("t1_dwell_end", door_open, 1'b1);
    step(1);
    chk("t1_door_close", door_open, 1'b0);
    // scan: at 3 going up with calls at 2 and 6
    cur_floor = 3'd3;
    press(7'b0100010);
    chk("t2_pending", pending, 7'b0100010);
    step(2);
    chk("t2_target", target, 3'd6);
    chk("t2_go", go, 1'b1);
    chk("t2_dir", dir_up, 1'b1);
    cur_floor = 3'd6;
    step(1);
    chk("t2_arr_go", go, 1'b0);
    chk("t2_arr_door", door_open, 1'b1);
    chk("t2_arr_pending", pending, 7'b0000010);
    step(7);
    chk("t2_dwell7", door_open, 1'b1);
    step(1);
    chk("t2_door_close", door_open, 1'b0);
    step(1);
    chk("t2_target2", target, 3'd2);
    chk("t2_dir_down", dir_up, 1'b0);
    chk("t2_go2", go, 1'b1);
    cur_floor = 3'd2;
    step(1);
    chk("t2_arr2_door", door_open, 1'b1);
    step(8);
    chk("t2_idle_door", door_open, 1'b0);
    chk("t2_idle_pending", pending, 7'b0);
    // call for the floor we are already on
    cur_floor = 3'd4;
    press(7'b0001000);
    chk("t3_pending", pending, 7'b0001000);
    step(1);
    chk("t3_sel_door", door_open, 1'b0);
    step(1);
    chk("t3_door", door_open, 1'b1);
    chk("t3_go", go, 1'b0);
    chk("t3_pending_clr", pending, 7'b0);
    chk("t3_target_kept", target, 3'd2);
    step(7);
    chk("t3_dwell7", door_open, 1'b1);
    step(1);
    chk("t3_close", door_open, 1'b0);
    chk("t3_go_end", go, 1'b0);
    // only-above while heading down flips to up; then re-press during dwell
    cur_floor = 3'd2;
    press(7'b0000100);
    step(2);
    chk("t4_target", target, 3'd3);
    chk("t4_dir", dir_up, 1'b1);
    step(6);
    chk("t4_travel_go", go, 1'b1);
    cur_floor = 3'd3;
    btn[2] = 1'b1;
    step(1);
    chk("t4_arr_door", door_open, 1'b1);
    step(5);
    chk("t4_dwell5", door_open, 1'b1);
    step(1);
    chk("t4_press_pending", pending, 7'b0);
    btn[2] = 1'b0;
    step(7);
    chk("t4_restart_door", door_open, 1'b1);
    step(1);
    chk("t4_close", door_open, 1'b0);
    chk("t4_pending_end", pending, 7'b0);
    // async reset mid-travel
    cur_floor = 3'd6;
    press(7'b0010000);
    step(2);
    chk("t6_target", target, 3'd5);
    chk("t6_dir", dir_up, 1'b0);
    chk("t6_go", go, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_target", target, 3'd1);
    chk("t6_rst_go", go, 1'b0);
    chk("t6_rst_pending", pending, 7'b0);
    chk("t6_rst_dir", dir_up, 1'b1);
    #2;
    rst_n = 1'b1;
    @(negedge clk);
    // second press on the current target
    cur_floor = 3'd1;
    press(7'b1000000);
    step(2);
    chk("t5_target", target, 3'd7);
    chk("t5_go", go, 1'b1);
    step(6);
    press(7'b1000000);
`ifdef CALL_SCHED_CANCEL_EN
    chk("t5_cancel_pending", pending, 7'b0);
    chk("t5_cancel_go", go, 1'b0);
    step(1);
    chk("t5_cancel_idle_go", go, 1'b0);
`else
    chk("t5_keep_pending", pending, 7'b1000000);
    chk("t5_keep_go", go, 1'b1);
    step(1);
    chk("t5_keep_target", target, 3'd7);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule

// File: doc/call_scheduler.md
# call_scheduler

Upstream request stage for the elevator controller. Debounces the seven hall/cab call buttons, latches them into a pending-request register and picks the next target floor with a SCAN (keep-direction) policy. It drives the floor-select/go pair consumed by the elevator FSM and watches the reported current floor to retire requests and time the door-open dwell.

## Interface
- DEBOUNCE_CYCLES, 1_000_000: consecutive stable cycles (10 ms at 100 MHz) before a button level is accepted
- DWELL_CYCLES, 200_000_000: door-open time at a served floor, in cycles
- clk  input  1  system clock
- rst_n  input  1  reset; one clock, reset is asynchronous and active-low
- BTN  input  7  raw buttons; BTN[i] calls floor i+1; asynchronous, bouncy
- cur_floor  input  3  current elevator floor, 1..7; value 0 is treated as 1
- target  output  3  selected target floor (elevator floor select)
- go  output  1  move enable (elevator go bit); high only while travelling to target
- pending  output  7  latched requests, bit i = floor i+1
- door_open  output  1  high during dwell
- dir_up  output  1  current scan direction, 1 = up

## Operation
- Input path: per button, 2-flop synchroniser, then debounce counter; counter resets on any level change and the accepted level updates when it reaches DEBOUNCE_CYCLES-1. A rising edge of the accepted level gives a one-cycle press pulse.
- A press pulse sets pending[i] on the next edge; an already-set bit stays set.
- States: IDLE, SELECT, SERVE, DWELL.
- IDLE: pending == 0 -> stay, go=0. pending != 0 -> SELECT.
- SELECT (one cycle), with cf = cur_floor:
  - If pending[cf-1] is set -> clear it, door_open=1, DWELL.
  - If dir_up and a pending floor exists above cf -> target = lowest such floor.
  - Else if a pending floor exists below cf -> dir_up=0, target = highest such floor.
  - Else (only above, dir down) -> dir_up=1, target = lowest above.
  - When a target is chosen, go=1 and the FSM goes to SERVE.
- SERVE: cur_floor == target -> clear pending[target-1], go=0, door_open=1, dwell counter=0, DWELL. A new press is only latched; the target is not re-chosen mid-travel.
- DWELL: counter counts to DWELL_CYCLES-1, then door_open=0 and SELECT if pending != 0, else IDLE. A press for cur_floor during DWELL is dropped (not latched) and restarts the dwell counter.

## Timing
- Reset values: target=3'd1, go=0, pending=7'b0, door_open=0, dir_up=1, state IDLE, all counters 0, debounced levels 0.
- BTN edge to pending bit: 2 (sync) + DEBOUNCE_CYCLES + 1 cycles.
- pending set to target/go valid: IDLE->SELECT 1 cycle, SELECT->outputs registered 1 cycle. Total 2 cycles.
- Arrival (cur_floor==target sampled) to go=0 and door_open=1: 1 cycle.
- A press and a clear of the same bit on the same edge: the clear wins.
- Asynchronous reset mid-travel or mid-dwell: all outputs go to reset values immediately. Requests are lost.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Configuration
- CALL_SCHED_CANCEL_EN defined: a press on a floor whose pending bit is already set clears that bit (toggle). If that floor is the current target in SERVE, go drops next cycle and the FSM returns to SELECT (or IDLE if pending becomes 0).
- Undefined: presses on already-pending floors are ignored. No cancel logic is synthesised.

## Structure
- Shared package elevator_pkg holds: FLOOR_W=3, NUM_FLOORS=7, the state enum encoding (IDLE=2'b00, SELECT=2'b01, SERVE=2'b10, DWELL=2'b11) and floor-to-bit helper constants.
- One sub-module, btn_debounce: synchroniser, counter and edge pulse for one button, parameterised by DEBOUNCE_CYCLES. It is instantiated 7 times in a generate loop.
- The scan-select priority search is a combinational function inside call_scheduler.

## Test plan
Benches use DEBOUNCE_CYCLES=4 and DWELL_CYCLES=8.
- Reset, then bounce BTN[4] with 3-cycle glitches, then hold it stable -> no pending bit during the glitches; pending=7'b0010000 after a stable hold of 2+4+1 cycles; target=5, go=1 two cycles later.
- cur_floor=3, dir_up=1, pending floors 2 and 6 -> target=6. Drive cur_floor=6 -> go=0, door_open=1 for 8 cycles, then target=2, dir_up=0.
- cur_floor=4, press floor 4 in IDLE -> no go, door_open=1 for 8 cycles, pending returns to 0, IDLE.
- During DWELL at floor 3, press floor 3 at dwell cycle 5 -> pending unchanged, door_open stays high 8 cycles from the press.
- With CALL_SCHED_CANCEL_EN, target=7 in SERVE, press floor 7 again -> pending[6]=0, go=0 next cycle, FSM returns to IDLE. Without the macro, the same stimulus leaves target=7 and go=1.
- Assert rst_n low mid-SERVE -> target=1, go=0, pending=0, dir_up=1 immediately, without waiting for a clock edge.
